multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cu_pkg.sv | 49 ++++
 rtl/alu_decoder.sv | 39 +++
 rtl/multicycle_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings for the multicycle control unit and its ALU decoder
package cu_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL,
        S_EXECU, S_JALRT, S_JALRWB
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
        ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
    } alu_ctrl_e;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALUOp, funct3, funct7b5 and opcode bit 5 to the ALU operation code
module alu_decoder
    import cu_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [1:0]            i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_op5,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    alu_ctrl_e w_code;

    always_comb begin
        w_code = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: w_code = ALU_ADD;
            ALUOP_SUB: w_code = ALU_SUB;
            default: begin
                // bit 30 only means SUB for register-register ops; addi keeps it as immediate bits
                case (i_funct3)
                    3'b000:  w_code = (i_funct7b5 && i_op5) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_code = ALU_SLL;
                    3'b010:  w_code = ALU_SLT;
                    3'b011:  w_code = ALU_SLTU;
                    3'b100:  w_code = ALU_XOR;
                    3'b101:  w_code = i_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  w_code = ALU_OR;
                    default: w_code = ALU_AND;
                endcase
            end
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM; CU_UPPER_JALR_EN adds LUI/AUIPC/JALR
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int INSTRET_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  logic                  Zero_i,
    input  logic                  Lt_i,
    input  logic                  mem_ready_i,
    output logic                  PCWrite_o,
    output logic                  AdrSrc_o,
    output logic                  MemWrite_o,
    output logic                  IRWrite_o,
    output logic [1:0]            ResultSrc_o,
    output logic [1:0]            ALUSrcA_o,
    output logic [1:0]            ALUSrcB_o,
    output logic [2:0]            ImmSrc_o,
    output logic [ALU_CTRL_W-1:0] ALUControl_o,
    output logic                  RegWrite_o,
    output logic                  illegal_o,
    output logic [INSTRET_W-1:0]  instret_o
);

    state_e                 r_state;
    state_e                 w_next;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   w_retire;
    logic                   w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_adr_src, w_illegal;
    res_src_e               w_result_src;
    src_a_e                 w_src_a;
    src_b_e                 w_src_b;
    imm_src_e               w_imm_src;
    alu_op_e                w_alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_illegal    = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = mem_ready_i;
                w_pc_write   = mem_ready_i;
                if (mem_ready_i)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                // OldPC + B-immediate is precomputed here for a possible branch
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_B;
                case (opcode_i)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_I:              w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
`ifdef CU_UPPER_JALR_EN
                    OP_LUI, OP_AUIPC:  w_next = S_EXECU;
                    OP_JALR:           w_next = S_JALRT;
`endif
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                if (opcode_i[5]) begin
                    w_imm_src = IMM_S;
                    w_next    = S_MEMWRITE;
                end else begin
                    w_imm_src = IMM_I;
                    w_next    = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (mem_ready_i)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready_i) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALUOP_SUB;
                w_next   = S_FETCH;
                // funct3[2] selects the Lt family, funct3[0] inverts the condition
                if (funct3_i[2:1] == 2'b01) begin
                    w_illegal = 1'b1;
                end else begin
                    w_pc_write = funct3_i[2] ? (Lt_i ^ funct3_i[0]) : (Zero_i ^ funct3_i[0]);
                    w_retire   = 1'b1;
                end
            end
            S_JAL: begin
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
                w_imm_src  = IMM_J;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
`ifdef CU_UPPER_JALR_EN
            S_EXECU: begin
                w_src_a   = opcode_i[5] ? SRCA_ZERO : SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_U;
                w_next    = S_ALUWB;
            end
            S_JALRT: begin
                w_src_a      = SRCA_RS1;
                w_src_b      = SRCB_IMM;
                w_result_src = RES_ALURESULT;
                w_pc_write   = 1'b1;
                w_next       = S_JALRWB;
            end
            S_JALRWB: begin
                w_src_a      = SRCA_OLDPC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3_i),
        .i_funct7b5    (funct7b5_i),
        .i_op5         (opcode_i[5]),
        .o_alu_control (ALUControl_o)
    );

    // strobes are gated by rst_n so they drop the instant reset asserts
    assign PCWrite_o   = w_pc_write  & rst_n;
    assign IRWrite_o   = w_ir_write  & rst_n;
    assign MemWrite_o  = w_mem_write & rst_n;
    assign RegWrite_o  = w_reg_write & rst_n;
    assign illegal_o   = w_illegal   & rst_n;
    assign AdrSrc_o    = w_adr_src;
    assign ResultSrc_o = w_result_src;
    assign ALUSrcA_o   = w_src_a;
    assign ALUSrcB_o   = w_src_b;
    assign ImmSrc_o    = w_imm_src;
    assign instret_o   = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
    import cu_pkg::*;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7b5, zero, lt, mem_ready;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]    result_src, src_a, src_b;
    logic [2:0]    imm_src;
    logic [3:0]    alu_ctrl;
    logic [IW-1:0] instret;

    multicycle_control_unit #(.ALU_CTRL_W(4), .INSTRET_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3), .funct7b5_i(funct7b5),
        .Zero_i(zero), .Lt_i(lt), .mem_ready_i(mem_ready), .PCWrite_o(pc_write), .AdrSrc_o(adr_src),
        .MemWrite_o(mem_write), .IRWrite_o(ir_write), .ResultSrc_o(result_src), .ALUSrcA_o(src_a),
        .ALUSrcB_o(src_b), .ImmSrc_o(imm_src), .ALUControl_o(alu_ctrl), .RegWrite_o(reg_write),
        .illegal_o(illegal), .instret_o(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        int            cycles;
        int            n_rw;
        int            n_pcw;
        int            n_mw;
        int            n_ill;
        logic [1:0]    rw_src;
        logic [3:0]    alu2;
        logic [IW-1:0] instret;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    int   retired = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (instr %0d): got %0h, expected %0h", nm, id, act, exp);
        end
    endtask

    function automatic bit upper_en();
`ifdef CU_UPPER_JALR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] alu_for(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return f7 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return l;
            3'd5, 3'd7: return !l;
            default:    return 1'b0;
        endcase
    endfunction

    // Expected per-instruction summary from DECODE up to and including the next completed fetch.
    task automatic run_instr(input int id, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic l, input int w, input int fw);
        exp_t e;
        logic mr [64];
        bit   mem_wait;
        bit   ok;
        e.id = id; e.cycles = 2; e.n_rw = 0; e.n_pcw = 0; e.n_mw = 0; e.n_ill = 1;
        e.rw_src = 2'b00; e.alu2 = ALU_ADD;
        mem_wait = 1'b0;
        ok = 1'b0;
        case (op)
            7'h33, 7'h13: begin e.cycles = 4; e.n_rw = 1; e.alu2 = alu_for(op == 7'h33, f3, f7); ok = 1'b1; end
            7'h03:        begin e.cycles = 5 + w; e.n_rw = 1; e.rw_src = 2'b01; mem_wait = 1'b1; ok = 1'b1; end
            7'h23:        begin e.cycles = 4 + w; e.n_mw = 1 + w; mem_wait = 1'b1; ok = 1'b1; end
            7'h63: begin
                e.cycles = 3;
                e.alu2 = ALU_SUB;
                if (f3 == 3'd2 || f3 == 3'd3) e.n_ill = 2;
                else begin e.n_pcw = int'(branch_taken(f3, z, l)); ok = 1'b1; end
            end
            7'h6F: begin e.cycles = 4; e.n_rw = 1; e.n_pcw = 1; ok = 1'b1; end
            7'h37, 7'h17: if (upper_en()) begin e.cycles = 4; e.n_rw = 1; ok = 1'b1; end
            7'h67: if (upper_en()) begin e.cycles = 4; e.n_rw = 1; e.n_pcw = 1; e.rw_src = 2'b10; ok = 1'b1; end
            default: ;
        endcase
        if (ok) e.n_ill = 0;
        else if (e.n_ill == 2) e.n_ill = 1;
        e.cycles += fw;
        if (ok) retired++;
        e.instret = retired[IW-1:0];

        for (int c = 1; c <= e.cycles; c++) mr[c] = 1'($urandom);
        if (mem_wait) begin
            for (int c = 3; c < 3 + w; c++) mr[c] = 1'b0;
            mr[3 + w] = 1'b1;
        end
        for (int c = e.cycles - fw; c < e.cycles; c++) mr[c] = 1'b0;
        mr[e.cycles] = 1'b1;

        opcode = op; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
        exp_q.push_back(e);
        for (int c = 1; c <= e.cycles; c++) begin
            mem_ready = mr[c];
            @(posedge clk); #1;
        end
    endtask

    int         m_cyc, m_rw, m_pcw, m_mw, m_ill, m_id;
    logic [1:0] m_rsrc;
    logic [3:0] m_alu2;
    bit         m_started = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (m_started) begin
                m_cyc++;
                if (m_cyc == 2) m_alu2 = alu_ctrl;
                if (reg_write) begin m_rw++; m_rsrc = result_src; end
                if (mem_write) m_mw++;
                if (illegal) m_ill++;
                if (pc_write && !ir_write) m_pcw++;
            end
            if (ir_write) begin
                chk("fetch_pcwrite", m_id, 32'(pc_write), 32'(1));
                if (m_started) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_fetch", m_id, 32'(0), 32'(1));
                    end else begin
                        e = exp_q.pop_front();
                        chk("cycles",      e.id, m_cyc,      e.cycles);
                        chk("regwrite_n",  e.id, m_rw,       e.n_rw);
                        chk("pcwrite_n",   e.id, m_pcw,      e.n_pcw);
                        chk("memwrite_n",  e.id, m_mw,       e.n_mw);
                        chk("illegal_n",   e.id, m_ill,      e.n_ill);
                        chk("wb_resultsrc",e.id, 32'(m_rsrc), 32'(e.rw_src));
                        chk("alu_control", e.id, 32'(m_alu2), 32'(e.alu2));
                        chk("instret",     e.id, 32'(instret), 32'(e.instret));
                        m_id = e.id + 1;
                    end
                end
                m_started = 1'b1;
                m_cyc = 0; m_rw = 0; m_pcw = 0; m_mw = 0; m_ill = 0;
                m_rsrc = 2'b00; m_alu2 = 4'hF;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] word;
        int          id;
        logic [6:0]  op;
        int          w;
        m_id = 0;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
        @(posedge clk); #3;
        chk("rst_pcwrite",  -1, 32'(pc_write),  32'(0));
        chk("rst_irwrite",  -1, 32'(ir_write),  32'(0));
        chk("rst_regwrite", -1, 32'(reg_write), 32'(0));
        chk("rst_memwrite", -1, 32'(mem_write), 32'(0));
        chk("rst_illegal",  -1, 32'(illegal),   32'(0));
        chk("rst_instret",  -1, 32'(instret),   32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        chk("fetch_wait_irwrite", -1, 32'(ir_write), 32'(0));
        chk("fetch_alusrcb",      -1, 32'(src_b),    32'(2));
        chk("fetch_resultsrc",    -1, 32'(result_src), 32'(2));
        chk("fetch_adrsrc",       -1, 32'(adr_src),  32'(0));
        @(posedge clk); #1;
        chk("fetch_hold_irwrite", -1, 32'(ir_write), 32'(0));

        mon_en = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;

        id = 0;
        word = 32'h002081B3;
        run_instr(id++, word[6:0], word[14:12], word[30], 1'b0, 1'b0, 0, 0);
        run_instr(id++, 7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 3, 0);
        run_instr(id++, 7'h63, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(id++, 7'h63, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(id++, 7'h63, 3'd2, 1'b0, 1'b1, 1'b1, 0, 1);
        run_instr(id++, 7'h37, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(id++, 7'h23, 3'd2, 1'b1, 1'b0, 1'b0, 2, 1);
        run_instr(id++, 7'h33, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(id++, 7'h13, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(id++, 7'h13, 3'd5, 1'b1, 1'b0, 1'b0, 0, 2);
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23; 4: op = 7'h63;
                5: op = 7'h6F; 6: op = 7'h37; 7: op = 7'h17; 8: op = 7'h67;
                default: op = 7'($urandom);
            endcase
            w = (op == 7'h03 || op == 7'h23) ? $urandom_range(0, 3) : 0;
            run_instr(id++, op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), w,
                      $urandom_range(0, 2));
        end
        mon_en = 1'b0;
        chk("queue_drained", -1, exp_q.size(), 0);

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b1; opcode = 7'h23; funct3 = 3'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("memwrite_wait1", -2, 32'(mem_write), 32'(1));
        @(posedge clk); #1;
        chk("memwrite_wait2", -2, 32'(mem_write), 32'(1));
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memwrite", -2, 32'(mem_write), 32'(0));
        chk("rst_mid_irwrite",  -2, 32'(ir_write),  32'(0));
        chk("rst_mid_pcwrite",  -2, 32'(pc_write),  32'(0));
        chk("rst_mid_instret",  -2, 32'(instret),   32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        chk("post_rst_irwrite", -2, 32'(ir_write), 32'(0));
        chk("post_rst_alusrcb", -2, 32'(src_b),    32'(2));
        chk("post_rst_adrsrc",  -2, 32'(adr_src),  32'(0));
        mem_ready = 1'b1;
        #1;
        chk("post_rst_fetch",   -2, 32'(ir_write), 32'(1));
        @(posedge clk); #1;
        chk("post_rst_instret", -2, 32'(instret),  32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
